// File: rtl/reg_file_sb_if.sv
// Issue/writeback-side bus of the scoreboarded register file: read ports,
// two byte-enabled write ports, reservation request and busy count.
interface reg_file_sb_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned NUM_RD     = 2
);
  localparam int unsigned NB = REG_WIDTH / 8;

  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr;
  logic [NUM_RD*REG_WIDTH-1:0]  o_rd_val;
  logic [NUM_RD-1:0]            o_rd_busy;
  logic [1:0]                   i_wr_en;
  logic [2*ADDR_WIDTH-1:0]      i_wr_addr;
  logic [2*REG_WIDTH-1:0]       i_wr_val;
  logic [2*NB-1:0]              i_wr_be;
  logic                         i_rsv_en;
  logic [ADDR_WIDTH-1:0]        i_rsv_addr;
  logic [ADDR_WIDTH:0]          o_busy_cnt;

  modport master (
    output i_rd_addr, i_wr_en, i_wr_addr, i_wr_val, i_wr_be, i_rsv_en, i_rsv_addr,
    input  o_rd_val, o_rd_busy, o_busy_cnt
  );

  modport slave (
    input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_val, i_wr_be, i_rsv_en, i_rsv_addr,
    output o_rd_val, o_rd_busy, o_busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with byte-enabled write bypass and per-register
// busy bits (scoreboard) for issue-stage hazard detection.
module reg_file_sb #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  reg_file_sb_if.slave  rf
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int unsigned NB       = REG_WIDTH / 8;

  logic [REG_WIDTH-1:0]  r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic [ADDR_WIDTH:0]   r_busy_cnt;

  logic [ADDR_WIDTH-1:0] w_wr_addr [2];
  logic [1:0]            w_wr_en;
  logic                  w_rsv_en;
  logic [REG_WIDTH-1:0]  w_regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_busy_cnt_nxt;
  logic [NUM_RD*REG_WIDTH-1:0] w_rd_val;
  logic [NUM_RD-1:0]     w_rd_busy;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualified enables: reset and hard-wired-zero hits are dropped here so
  // both the storage update and the bypass path see the same filtered writes.
  assign w_wr_addr[0] = rf.i_wr_addr[0 +: ADDR_WIDTH];
  assign w_wr_addr[1] = rf.i_wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wr_en[0]   = rf.i_wr_en[0] && !i_rst && !is_zero(w_wr_addr[0]);
  assign w_wr_en[1]   = rf.i_wr_en[1] && !i_rst && !is_zero(w_wr_addr[1]);
  assign w_rsv_en     = rf.i_rsv_en && !i_rst && !is_zero(rf.i_rsv_addr);

  // Port 1 is applied after port 0 so it wins on overlapping bytes.
  always_comb begin
    w_regs_nxt     = r_regs;
    w_busy_nxt     = r_busy;
    w_busy_cnt_nxt = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      if (w_wr_en[p]) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (rf.i_wr_be[p*NB + b])
            w_regs_nxt[w_wr_addr[p]][b*8 +: 8] = rf.i_wr_val[p*REG_WIDTH + b*8 +: 8];
        end
        w_busy_nxt[w_wr_addr[p]] = 1'b0;
      end
    end
    if (w_rsv_en)
      w_busy_nxt[rf.i_rsv_addr] = 1'b1;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      w_busy_cnt_nxt = w_busy_cnt_nxt + (ADDR_WIDTH+1)'(w_busy_nxt[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_regs     <= w_regs_nxt;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  // A same-cycle write clears the read busy flag unless a reservation to the
  // same register lands in this cycle too (the reservation wins at the edge).
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    logic [REG_WIDTH-1:0]  v;
    logic                  hit;
    w_rd_val  = '0;
    w_rd_busy = '0;
    a   = '0;
    v   = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a   = rf.i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      v   = r_regs[a];
      hit = 1'b0;
      for (int unsigned p = 0; p < 2; p++) begin
        if (w_wr_en[p] && (w_wr_addr[p] == a)) begin
          hit = 1'b1;
          for (int unsigned b = 0; b < NB; b++) begin
            if (rf.i_wr_be[p*NB + b])
              v[b*8 +: 8] = rf.i_wr_val[p*REG_WIDTH + b*8 +: 8];
          end
        end
      end
      if (is_zero(a))
        v = '0;
      w_rd_val[k*REG_WIDTH +: REG_WIDTH] = v;
      w_rd_busy[k] = r_busy[a] && !(hit && !(w_rsv_en && (rf.i_rsv_addr == a)));
    end
  end

  assign rf.o_rd_val   = w_rd_val;
  assign rf.o_rd_busy  = w_rd_busy;
  assign rf.o_busy_cnt = r_busy_cnt;
endmodule
